// File: rtl/l2_l1req_if.sv
// L1 <-> L2 miss-path bundle: coherence requests, snack responses and displacements.
interface l2_l1req_if #(
   parameter int unsigned TAG_BITS = 10
);
   logic                l1tol2_req_valid;
   logic                l1tol2_req_retry;
   logic [2:0]          l1tol2_req;
   logic [TAG_BITS-1:0] l1tol2_req_tag;

   logic                l2tol1_snack_valid;
   logic [4:0]          l2tol1_snack;
   logic [TAG_BITS-1:0] l2tol1_snack_tag;

   logic                l1tol2_disp_valid;
   logic                l1tol2_disp_retry;
   logic [2:0]          l1tol2_disp;

   logic [7:0]          disp_count;
   logic                err_unknown;

   // L2 side
   modport slave (
      input  l1tol2_req_valid, l1tol2_req, l1tol2_req_tag,
      input  l1tol2_disp_valid, l1tol2_disp,
      output l1tol2_req_retry, l1tol2_disp_retry,
      output l2tol1_snack_valid, l2tol1_snack, l2tol1_snack_tag,
      output disp_count, err_unknown
   );

   // L1 side
   modport master (
      output l1tol2_req_valid, l1tol2_req, l1tol2_req_tag,
      output l1tol2_disp_valid, l1tol2_disp,
      input  l1tol2_req_retry, l1tol2_disp_retry,
      input  l2tol1_snack_valid, l2tol1_snack, l2tol1_snack_tag,
      input  disp_count, err_unknown
   );
endinterface

// File: rtl/l2_l1req_responder.sv
// L2 responder for the L1 miss path: queues requests in order, answers each with an
// ACK snack after a fixed service latency, and counts displacements.
module l2_l1req_responder #(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned LAT      = 3,
   parameter int unsigned TAG_BITS = 10
) (
   input  logic            clk,
   input  logic            reset,
   l2_l1req_if.slave       bus
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned LAT_W = (LAT > 1) ? $clog2(LAT) : 1;

   localparam logic [2:0] SC_CMD_REQ_S  = 3'b000;
   localparam logic [2:0] SC_CMD_REQ_M  = 3'b001;
   localparam logic [4:0] SC_SCMD_ACK_S = 5'b00001;
   localparam logic [4:0] SC_SCMD_ACK_M = 5'b00010;

   typedef struct packed {
      logic [4:0]          cmd;
      logic [TAG_BITS-1:0] tag;
   } entry_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t             state_q;
   entry_t             mem_q [DEPTH];
   entry_t             work_q;
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [CNT_W-1:0]   count_q;
   logic [LAT_W-1:0]   lat_cnt_q;
   logic               snack_valid_q;
   logic [4:0]         snack_q;
   logic [TAG_BITS-1:0] snack_tag_q;
   logic [7:0]         disp_count_q;
   logic               err_unknown_q;

   logic               req_retry_c;
   logic               req_fire_c;
   logic               req_known_c;
   logic               push_c;
   logic               pop_c;
   logic               fifo_nonempty_c;
   entry_t             new_entry_c;
   logic               unused_disp_c;

   // Back-pressure looks only at registered occupancy; a same-cycle pop never frees a slot.
   assign req_retry_c     = reset || (count_q == CNT_W'(DEPTH));
   assign req_fire_c      = bus.l1tol2_req_valid && !req_retry_c;
   assign req_known_c     = (bus.l1tol2_req == SC_CMD_REQ_S) || (bus.l1tol2_req == SC_CMD_REQ_M);
   assign push_c          = req_fire_c && req_known_c;
   assign fifo_nonempty_c = (count_q != '0);
   assign pop_c           = ((state_q == S_IDLE) || (state_q == S_RESP)) && fifo_nonempty_c;

   assign new_entry_c.cmd = (bus.l1tol2_req == SC_CMD_REQ_S) ? SC_SCMD_ACK_S : SC_SCMD_ACK_M;
   assign new_entry_c.tag = bus.l1tol2_req_tag;

   // Displacement command value carries no meaning for this responder.
   assign unused_disp_c   = ^bus.l1tol2_disp;

   // Request FIFO and service FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         lat_cnt_q     <= '0;
         work_q        <= '0;
         snack_valid_q <= 1'b0;
         snack_q       <= '0;
         snack_tag_q   <= '0;
      end else begin
         snack_valid_q <= 1'b0;
         snack_q       <= '0;
         snack_tag_q   <= '0;

         if (push_c) begin
            mem_q[wr_ptr_q] <= new_entry_c;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_c) begin
            work_q    <= mem_q[rd_ptr_q];
            rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
            lat_cnt_q <= LAT_W'(LAT - 1);
         end

         case ({push_c, pop_c})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase

         case (state_q)
            S_IDLE: begin
               if (fifo_nonempty_c) state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (lat_cnt_q == '0) begin
                  state_q       <= S_RESP;
                  snack_valid_q <= 1'b1;
                  snack_q       <= work_q.cmd;
                  snack_tag_q   <= work_q.tag;
               end else begin
                  lat_cnt_q <= lat_cnt_q - LAT_W'(1);
               end
            end
            S_RESP: begin
               state_q <= fifo_nonempty_c ? S_WAIT : S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Displacement counter and sticky unknown-request flag
   always_ff @(posedge clk) begin
      if (reset) begin
         disp_count_q  <= '0;
         err_unknown_q <= 1'b0;
      end else begin
         if (bus.l1tol2_disp_valid && (disp_count_q != 8'hFF)) begin
            disp_count_q <= disp_count_q + 8'(1);
         end
         if (req_fire_c && !req_known_c) begin
            err_unknown_q <= 1'b1;
         end
      end
   end

   assign bus.l1tol2_req_retry   = req_retry_c;
   assign bus.l1tol2_disp_retry  = reset;
   assign bus.l2tol1_snack_valid = snack_valid_q;
   assign bus.l2tol1_snack       = snack_q;
   assign bus.l2tol1_snack_tag   = snack_tag_q;
   assign bus.disp_count         = disp_count_q;
   assign bus.err_unknown        = err_unknown_q;

endmodule

// File: tb/tb_l2_l1req_responder.sv
// Scoreboard bench for l2_l1req_responder: a timing model predicts each snack's cycle,
// command and tag, plus per-cycle retry, displacement count and error flag.
module tb_l2_l1req_responder;

   localparam int unsigned DEPTH    = 4;
   localparam int unsigned LAT      = 3;
   localparam int unsigned TAG_BITS = 10;

   localparam logic [2:0] REQ_S = 3'b000;
   localparam logic [2:0] REQ_M = 3'b001;
   localparam logic [2:0] BAD   = 3'b111;
   localparam logic [4:0] ACK_S = 5'b00001;
   localparam logic [4:0] ACK_M = 5'b00010;

   typedef struct {
      logic [4:0]          cmd;
      logic [TAG_BITS-1:0] tag;
      int                  cyc;
   } sb_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   n_chk = 0;
   int   n_err = 0;

   sb_t  sb[$];
   int   pop_q[$];
   int   occ       = 0;
   int   prev_resp = 0;
   int   disp_m    = 0;
   logic err_m     = 1'b0;
   logic push_pend = 1'b0;
   logic disp_pend = 1'b0;
   logic err_pend  = 1'b0;
   sb_t  mon_e;

   l2_l1req_if #(.TAG_BITS(TAG_BITS)) bus ();

   l2_l1req_responder #(
      .DEPTH    (DEPTH),
      .LAT      (LAT),
      .TAG_BITS (TAG_BITS)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   // Snack monitor: every issued snack must match the scoreboard head at its predicted cycle.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         mon_e = sb.pop_front();
         chk("missed_snack", 32'(cyc), 32'(mon_e.cyc));
      end
      if (bus.l2tol1_snack_valid) begin
         if (sb.size() == 0) begin
            chk("spurious_snack", 32'(1), 32'(0));
         end else begin
            mon_e = sb.pop_front();
            chk("snack_cmd", 32'(bus.l2tol1_snack), 32'(mon_e.cmd));
            chk("snack_tag", 32'(bus.l2tol1_snack_tag), 32'(mon_e.tag));
            chk("snack_cycle", 32'(cyc), 32'(mon_e.cyc));
         end
      end else begin
         chk("idle_snack_zero", 32'({bus.l2tol1_snack, bus.l2tol1_snack_tag}), 32'(0));
      end
   end

   // One clock of stimulus; updates the occupancy/latency model and checks per-cycle outputs.
   task automatic tick(input logic rst, input logic v, input logic [2:0] c,
                       input logic [TAG_BITS-1:0] tg, input logic dv, output logic acc);
      logic exp_retry;
      int   start;
      @(negedge clk);
      if (push_pend) occ++;
      if (disp_pend && disp_m < 255) disp_m++;
      if (err_pend) err_m = 1'b1;
      push_pend = 1'b0;
      disp_pend = 1'b0;
      err_pend  = 1'b0;
      while (pop_q.size() > 0 && pop_q[0] < cyc) begin
         void'(pop_q.pop_front());
         occ--;
      end
      chk("disp_count", 32'(bus.disp_count), 32'(disp_m));
      chk("err_unknown", 32'(bus.err_unknown), 32'(err_m));

      reset                 = rst;
      bus.l1tol2_req_valid  = v;
      bus.l1tol2_req        = c;
      bus.l1tol2_req_tag    = tg;
      bus.l1tol2_disp_valid = dv;
      bus.l1tol2_disp       = 3'($urandom_range(7));
      #1;
      exp_retry = rst || (occ == int'(DEPTH));
      chk("req_retry", 32'(bus.l1tol2_req_retry), 32'(exp_retry));
      chk("disp_retry", 32'(bus.l1tol2_disp_retry), 32'(rst));
      acc = v && !exp_retry;

      if (rst) begin
         sb.delete();
         pop_q.delete();
         occ       = 0;
         prev_resp = 0;
         disp_m    = 0;
         err_m     = 1'b0;
      end else begin
         if (acc) begin
            if (c == REQ_S || c == REQ_M) begin
               start     = (cyc + 1 > prev_resp) ? cyc + 1 : prev_resp;
               prev_resp = start + int'(LAT) + 1;
               pop_q.push_back(start);
               push_pend = 1'b1;
               sb.push_back('{(c == REQ_S) ? ACK_S : ACK_M, tg, prev_resp});
            end else begin
               err_pend = 1'b1;
            end
         end
         if (dv) disp_pend = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      logic a;
      repeat (n) tick(1'b0, 1'b0, REQ_S, '0, 1'b0, a);
   endtask

   task automatic send(input logic [2:0] c, input logic [TAG_BITS-1:0] tg, output int retries);
      logic a;
      a       = 1'b0;
      retries = 0;
      for (int k = 0; k < 32; k++) begin
         tick(1'b0, 1'b1, c, tg, 1'b0, a);
         if (a) break;
         retries++;
      end
      if (!a) chk("send_timeout", 32'(0), 32'(1));
   endtask

   initial begin
      logic a;
      int   r;
      int   tot;
      bus.l1tol2_req_valid  = 1'b0;
      bus.l1tol2_req        = '0;
      bus.l1tol2_req_tag    = '0;
      bus.l1tol2_disp_valid = 1'b0;
      bus.l1tol2_disp       = '0;

      repeat (3) tick(1'b1, 1'b0, REQ_S, '0, 1'b0, a);
      while (cyc < 9) idle(1);

      // Single REQ_S accepted at cycle 10, snack predicted at 15
      send(REQ_S, 10'h155, r);
      chk("single_accept_retries", 32'(r), 32'(0));
      idle(10);

      // Five back-to-back REQ_M
      tot = 0;
      for (int i = 1; i <= 5; i++) begin
         send(REQ_M, TAG_BITS'(i), r);
         tot += r;
      end
      idle(30);

      // Longer burst to fill the FIFO and hit retry while a pop is in progress
      tot = 0;
      for (int i = 0; i < 8; i++) begin
         send(REQ_M, TAG_BITS'(16 + i), r);
         tot += r;
      end
      chk("full_retry_seen", 32'(tot > 0), 32'(1));
      idle(40);

      // Unsupported request code
      send(BAD, 10'h3AA, r);
      chk("bad_code_no_retry", 32'(r), 32'(0));
      idle(10);

      // 300 displacement cycles with sparse requests interleaved
      for (int i = 0; i < 300; i++) begin
         if (i % 7 == 3)
            tick(1'b0, 1'b1, (i % 14 == 3) ? REQ_S : REQ_M, TAG_BITS'(i), 1'b1, a);
         else
            tick(1'b0, 1'b0, REQ_S, '0, 1'b1, a);
      end
      idle(30);
      chk("disp_saturated", 32'(bus.disp_count), 32'(255));

      // Reset while WAIT holds three queued entries
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 1'b1, REQ_S, TAG_BITS'(10'h100 + i), 1'b0, a);
         chk("pre_rst_accept", 32'(a), 32'(1));
      end
      tick(1'b1, 1'b0, REQ_S, '0, 1'b0, a);
      idle(3);
      chk("post_rst_no_retry", 32'(bus.l1tol2_req_retry), 32'(0));
      idle(10);
      send(REQ_S, 10'h02A, r);
      idle(20);

      chk("scoreboard_drained", 32'(sb.size()), 32'(0));
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
